// File: rtl/reg_file_swap.sv
// reg_file_swap: register file with one write port, two registered read ports and an atomic two-cycle swap
module reg_file_swap #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WRITE_EN,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WORD_SIZE-1:0] in,
  input  logic                 READ_EN,
  input  logic [ADDR_W-1:0]    raddr_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  input  logic                 SWAP_EN,
  input  logic [ADDR_W-1:0]    swap_a,
  input  logic [ADDR_W-1:0]    swap_b,
  output logic                 busy,
  output logic                 swap_done,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, S_READ, S_WRITE} state_t;
  state_t state_q;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] tmp_a_q, tmp_b_q, out_a_q, out_b_q, rd_a_d, rd_b_d;
  logic [ADDR_W-1:0] sa_q, sb_q;
  logic busy_q, done_q, err_q, err_d;
  logic idle, wr_req, wr_bad, sw_bad, ra_bad, rb_bad, we;
  assign idle   = state_q == IDLE;
  assign wr_req = idle && WRITE_EN && !SWAP_EN;
  assign wr_bad = 32'(waddr) >= DEPTH;
  assign sw_bad = 32'(swap_a) >= DEPTH || 32'(swap_b) >= DEPTH;
  assign ra_bad = 32'(raddr_a) >= DEPTH;
  assign rb_bad = 32'(raddr_b) >= DEPTH;
  assign we     = wr_req && !wr_bad;
  // write-first: a committed write to the address being read bypasses the array
  always_comb begin
    rd_a_d = ra_bad ? '0 : (we && waddr == raddr_a) ? in : mem_q[raddr_a];
    rd_b_d = rb_bad ? '0 : (we && waddr == raddr_b) ? in : mem_q[raddr_b];
    err_d  = (wr_req && wr_bad) || (idle && SWAP_EN && sw_bad) || (READ_EN && (ra_bad || rb_bad));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= 1'b0;
      if (READ_EN) begin
        out_a_q <= rd_a_d;
        out_b_q <= rd_b_d;
      end
      if (we) mem_q[waddr] <= in;
      case (state_q)
        IDLE: if (SWAP_EN && !sw_bad) begin
          sa_q    <= swap_a;
          sb_q    <= swap_b;
          busy_q  <= 1'b1;
          state_q <= S_READ;
        end
        S_READ: begin
          tmp_a_q <= mem_q[sa_q];
          tmp_b_q <= mem_q[sb_q];
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          mem_q[sa_q] <= tmp_b_q;
          mem_q[sb_q] <= tmp_a_q;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign busy      = busy_q;
  assign swap_done = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_reg_file_swap.sv
// tb_reg_file_swap: scoreboard bench for reg_file_swap with DEPTH=10
module tb_reg_file_swap;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wen = 1'b0, ren = 1'b0, sen = 1'b0;
  logic [3:0] waddr = '0, ra = '0, rb = '0, sa = '0, sb = '0;
  logic [15:0] din = '0;
  logic [15:0] out_a, out_b;
  logic busy, swap_done, err;
  int cyc = 0, n_cmp = 0, n_bad = 0, bcnt = 0;
  typedef struct {int c; logic [15:0] a; logic [15:0] b;} rexp_t;
  rexp_t rq[$];
  int eq[$], dq[$];

  reg_file_swap #(.WORD_SIZE(16), .DEPTH(10), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .WRITE_EN(wen), .waddr(waddr), .in(din),
    .READ_EN(ren), .raddr_a(ra), .raddr_b(rb), .out_a(out_a), .out_b(out_b),
    .SWAP_EN(sen), .swap_a(sa), .swap_b(sb), .busy(busy), .swap_done(swap_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rexp_t r;
    if (!rst_n) bcnt = 0;
    else if (busy) bcnt++;
    if (rq.size() > 0 && rq[0].c <= cyc) begin
      r = rq.pop_front();
      check("rd_cycle", cyc, r.c);
      check("out_a", out_a, r.a);
      check("out_b", out_b, r.b);
    end
    if (err) begin
      if (eq.size() == 0) check("err_spurious", err, 0);
      else check("err_cycle", cyc, eq.pop_front());
    end
    if (swap_done) begin
      if (dq.size() == 0) check("done_spurious", swap_done, 0);
      else check("done_cycle", cyc, dq.pop_front());
      check("busy_len", bcnt, 2);
      bcnt = 0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wen = 1'b1; waddr = a; din = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [15:0] ea, input logic [15:0] eb);
    ren = 1'b1; ra = a; rb = b;
    rq.push_back('{cyc + 1, ea, eb});
    @(negedge clk);
    ren = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", swap_done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // basic write/read
    wr(0, 23); wr(1, 24); wr(2, 25);
    rd(0, 2, 23, 25);
    rd(1, 3, 24, 0);
    for (int i = 4; i < 10; i++) rd(4'(i), 4'(i), 0, 0);
    // read-during-write returns the new data
    wr(5, 9);
    wen = 1'b1; waddr = 5; din = 77; ren = 1'b1; ra = 5; rb = 0;
    rq.push_back('{cyc + 1, 77, 23});
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    rd(5, 5, 77, 77);
    // swap 3<->7 with writes and a second swap ignored while busy
    wr(3, 40); wr(7, 11);
    sen = 1'b1; sa = 3; sb = 7;
    dq.push_back(cyc + 3);
    @(negedge clk);
    sen = 1'b0; wen = 1'b1; waddr = 3; din = 55; ren = 1'b1; ra = 3; rb = 7;
    rq.push_back('{cyc + 1, 40, 11});
    @(negedge clk);
    sen = 1'b1; sa = 0; sb = 1;
    rq.push_back('{cyc + 1, 40, 11});
    @(negedge clk);
    sen = 1'b0; wen = 1'b0; ren = 1'b0;
    rd(3, 7, 11, 40);
    rd(0, 1, 23, 24);
    // self-swap with a concurrent write that must be dropped
    wr(4, 99);
    sen = 1'b1; sa = 4; sb = 4; wen = 1'b1; waddr = 6; din = 123;
    dq.push_back(cyc + 3);
    @(negedge clk);
    sen = 1'b0; wen = 1'b0;
    repeat (2) @(negedge clk);
    rd(4, 6, 99, 0);
    // out-of-range write, read, swap, and a combined offence
    wen = 1'b1; waddr = 12; din = 1;
    eq.push_back(cyc + 1);
    @(negedge clk);
    wen = 1'b0;
    @(negedge clk);
    ren = 1'b1; ra = 0; rb = 15;
    rq.push_back('{cyc + 1, 23, 0});
    eq.push_back(cyc + 1);
    @(negedge clk);
    ren = 1'b0;
    @(negedge clk);
    sen = 1'b1; sa = 11; sb = 0;
    eq.push_back(cyc + 1);
    @(negedge clk);
    sen = 1'b0;
    check("busy_rejected", busy, 0);
    @(negedge clk);
    check("busy_rejected2", busy, 0);
    wen = 1'b1; waddr = 12; din = 2; ren = 1'b1; ra = 15; rb = 13;
    rq.push_back('{cyc + 1, 0, 0});
    eq.push_back(cyc + 1);
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    @(negedge clk);
    rd(0, 1, 23, 24);
    rd(2, 9, 25, 0);
    // asynchronous reset in the middle of a swap
    rd(1, 2, 24, 25);
    sen = 1'b1; sa = 1; sb = 2;
    @(negedge clk);
    sen = 1'b0;
    check("busy_before_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_a", out_a, 0);
    check("arst_out_b", out_b, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(1, 2, 0, 0);
    rd(0, 3, 0, 0);
    wr(8, 321);
    rd(8, 0, 321, 0);
    repeat (5) @(negedge clk);
    check("rd_left", rq.size(), 0);
    check("err_left", eq.size(), 0);
    check("done_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
